// File: rtl/tpu_host_if_if.sv
// Core-side port bundle for tpu_host_if: weight/activation write port,
// run/done handshake and the result read port.
interface tpu_host_if_if #(
  parameter int AW = 2
) ();
  logic          mem_wr_en;
  logic          mem_wr_sel;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wr_data;
  logic          tpu_start;
  logic          tpu_done;
  logic [AW-1:0] res_rd_addr;
  logic [15:0]   res_rd_data;

  modport master (
    output mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data, tpu_start, res_rd_addr,
    input  tpu_done, res_rd_data
  );

  modport slave (
    input  mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data, tpu_start, res_rd_addr,
    output tpu_done, res_rd_data
  );
endinterface

// File: rtl/tpu_host_if.sv
// Byte-serial host front end for the TPU core. Define HOST_IF_SAT_EN to read
// one signed-saturated byte per result instead of two raw bytes (low, high).
module tpu_host_if #(
  parameter int N  = 2,
  parameter int AW = $clog2(N*N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           ui_in,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uo_out,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  tpu_host_if_if.master        core
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam logic [1:0]    CMD_LOAD_W = 2'b00;
  localparam logic [1:0]    CMD_LOAD_X = 2'b01;
  localparam logic [1:0]    CMD_RUN    = 2'b10;
  localparam logic [1:0]    CMD_READ   = 2'b11;
  localparam logic [AW-1:0] PTR_LAST   = AW'(N*N-1);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

`ifdef HOST_IF_SAT_EN
  function automatic logic [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127)       return 8'h7F;
    else if (v < -16'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction
`endif

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q, hist_q;
  logic [AW-1:0] w_ptr_q, w_ptr_d, x_ptr_q, x_ptr_d, r_ptr_q, r_ptr_d;
  logic          byte_sel_q, byte_sel_d;
  logic          out_valid_q, out_valid_d, err_q, err_d;
  logic [7:0]    uo_q, uo_d;
  logic          wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          start_q, start_d;
  logic          rise;
  logic [1:0]    cmd;
  logic          unused_uio;

  assign rise       = sync2_q & ~hist_q;
  assign cmd        = uio_in[2:1];
  assign unused_uio = ^uio_in[7:3];

  // Strobe synchroniser and rising-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= uio_in[0];
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_ptr_d     = w_ptr_q;
    x_ptr_d     = x_ptr_q;
    r_ptr_d     = r_ptr_q;
    byte_sel_d  = byte_sel_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    uo_d        = uo_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          case (cmd)
            CMD_LOAD_W: begin
              wr_en_d   = 1'b1;
              wr_sel_d  = 1'b0;
              wr_addr_d = w_ptr_q;
              wr_data_d = ui_in;
              w_ptr_d   = ptr_inc(w_ptr_q);
            end
            CMD_LOAD_X: begin
              wr_en_d   = 1'b1;
              wr_sel_d  = 1'b1;
              wr_addr_d = x_ptr_q;
              wr_data_d = ui_in;
              x_ptr_d   = ptr_inc(x_ptr_q);
            end
            CMD_RUN: begin
              start_d     = 1'b1;
              w_ptr_d     = '0;
              x_ptr_d     = '0;
              r_ptr_d     = '0;
              byte_sel_d  = 1'b0;
              out_valid_d = 1'b0;
              err_d       = 1'b0;
              state_d     = S_BUSY;
            end
            CMD_READ: begin
              out_valid_d = 1'b1;
`ifdef HOST_IF_SAT_EN
              uo_d    = sat8($signed(core.res_rd_data));
              r_ptr_d = ptr_inc(r_ptr_q);
`else
              // Low byte first; the result pointer moves on after the high byte
              uo_d       = byte_sel_q ? core.res_rd_data[15:8] : core.res_rd_data[7:0];
              byte_sel_d = ~byte_sel_q;
              if (byte_sel_q) r_ptr_d = ptr_inc(r_ptr_q);
`endif
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (rise)          err_d   = 1'b1;
        if (core.tpu_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Action edge: all host-visible and core-visible state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_ptr_q     <= '0;
      x_ptr_q     <= '0;
      r_ptr_q     <= '0;
      byte_sel_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      uo_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_ptr_q     <= w_ptr_d;
      x_ptr_q     <= x_ptr_d;
      r_ptr_q     <= r_ptr_d;
      byte_sel_q  <= byte_sel_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      uo_q        <= uo_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
    end
  end

  assign uo_out           = uo_q;
  assign uio_out          = {state_q == S_BUSY, out_valid_q, err_q, 5'b0};
  assign uio_oe           = 8'hE0;
  assign core.mem_wr_en   = wr_en_q;
  assign core.mem_wr_sel  = wr_sel_q;
  assign core.mem_wr_addr = wr_addr_q;
  assign core.mem_wr_data = wr_data_q;
  assign core.tpu_start   = start_q;
  assign core.res_rd_addr = r_ptr_q;

endmodule

// File: doc/tpu_host_if.md
# tpu_host_if

Byte-serial host front end for the TPU, placed between the Tiny Tapeout pins and the `tpu` core. It decodes strobed host transactions from `ui_in`/`uio_in`, which load weights and activations into the core, start a matrix run, and stream accumulator results back out on `uo_out`. Pin strobes are synchronised and edge-detected, and the block handles all pointer bookkeeping so the core sees plain write/start/read ports.

## Interface
- `N`, 2: matrix dimension; N*N weights, N*N activations, N*N results.
- `AW`, $clog2(N*N): address width for weights, activations and results.
- `clk` in 1: the single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `ui_in` in 8: host data byte.
- `uio_in` in 8: [0] host strobe; [2:1] command (00 LOAD_W, 01 LOAD_X, 10 RUN, 11 READ); [7:3] ignored.
- `uo_out` out 8: registered result byte.
- `uio_out` out 8: [7] busy, [6] out_valid, [5] err (sticky), [4:0] = 0.
- `uio_oe` out 8: constant 8'hE0.
- `mem_wr_en` out 1: one-cycle write pulse to the core.
- `mem_wr_sel` out 1: 0 = weight store, 1 = activation store.
- `mem_wr_addr` out AW: write address.
- `mem_wr_data` out 8: write data.
- `tpu_start` out 1: one-cycle run pulse.
- `tpu_done` in 1: core completion pulse.
- `res_rd_addr` out AW: result read address.
- `res_rd_data` in 16: core result; combinational read of `res_rd_addr`.

## Operation
- Strobe path: `uio_in[0]` goes through a 2-flop synchroniser plus one history flop. A transaction fires on a synchronised rising edge.
- Host contract: hold `ui_in` and `uio_in[2:1]` stable while the strobe is high. Minimum strobe high time is 3 cycles; minimum low time is 3 cycles.
- FSM states: IDLE and BUSY.
- IDLE behaviour by command:
  - LOAD_W: write `ui_in` to weight address `w_ptr`; `w_ptr` = (`w_ptr`+1) mod N*N.
  - LOAD_X: same as LOAD_W, using `x_ptr` and `mem_wr_sel`=1.
  - RUN: pulse `tpu_start`; clear `w_ptr`, `x_ptr`, `r_ptr`, `byte_sel`, out_valid and err; go to BUSY.
  - READ: load `uo_out` with the current result byte, set out_valid, then advance. Full-width advance: `byte_sel` toggles, low byte first; `r_ptr` increments (mod N*N) after the high byte.
- BUSY: busy=1. Any strobe is dropped and sets err. `tpu_done` returns the FSM to IDLE.
- `tpu_done` in IDLE: ignored.
- Wrap-around: a pointer past N*N-1 wraps to 0 silently; it is not an error.
- Simultaneous events: `tpu_done` and a dropped strobe in the same cycle set err and still return to IDLE.
- Reset (including mid-run) clears all state and outputs. The core is not notified; any in-flight `tpu_done` after reset is ignored.

## Timing
- Output reset values:
  - `uo_out`=0, `uio_out`=0.
  - `mem_wr_en`=0, `mem_wr_sel`=0, `mem_wr_addr`=0, `mem_wr_data`=0.
  - `tpu_start`=0, `res_rd_addr`=0.
  - `uio_oe`=8'hE0 always.
- Let t0 be the first clk edge sampling strobe high. The edge is detected after the edge at t1.
- Edge t2 is the action edge:
  - `mem_wr_*` register with `ui_in`/cmd sampled at t2.
  - `mem_wr_en` is high for exactly one cycle, t2 to t3.
  - `tpu_start` is high t2 to t3. busy is high from t2.
  - `uo_out` updates at t2 from `res_rd_data`.
- Latency is 2 cycles from strobe sampling to action.
- `tpu_done` sampled high at edge t clears busy at t.
- `res_rd_addr` = `r_ptr` and is registered.

## Configuration
- `HOST_IF_SAT_EN` defined:
  - READ returns one byte per result: `res_rd_data` signed-saturated to [-128, 127].
  - `r_ptr` increments on every READ.
- `HOST_IF_SAT_EN` undefined: two bytes per result, low then high (default).

## Test plan
- Reset, then 4 LOAD_W strobes with 8'h01..8'h04 -> four `mem_wr_en` pulses, addr 0..3, sel=0, data 01..04. A 5th strobe with 8'h05 -> addr 0.
- RUN, then a LOAD_X strobe during BUSY -> no `mem_wr_en`; err=1. `tpu_done` -> busy=0. Next RUN clears err.
- RUN with `tpu_done` 10 cycles later, then 8 READ strobes with `res_rd_data` = 16'h1234 at every address -> `uo_out` sequence 34,12 repeated. `res_rd_addr` steps 0..3 and returns to 0.
- With `HOST_IF_SAT_EN` defined: results 16'h0200, 16'hFF00, 16'h0005, 16'hFFFB -> READ bytes 7F, 80, 05, FB.
- Assert `rst_n`=0 mid-BUSY -> all outputs at reset values; `tpu_done` after release -> no state change.
- Strobe high for only 1 cycle -> behaviour undefined and not checked. Strobe high for 3 cycles -> exactly one `mem_wr_en` pulse.
